// File: rtl/seg_display_mux.sv
// Multiplexed N-digit seven-segment controller: captures a value, converts it to hex or
// (via sequential double-dabble) decimal, then scans the digits onto one segment bus.
module seg_display_mux #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned DIGITS         = 3,
  parameter int unsigned REFRESH_DIV    = 1024,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value_in,
  input  logic              load,
  input  logic              hex_mode,
  input  logic              signed_mode,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg_out,
  output logic              dp_out,
  output logic [DIGITS-1:0] digit_sel
);

  // Decimal digits needed to hold 2^w-1.
  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned max_v;
    longint unsigned lim;
    int unsigned     n;
    max_v = (longint'(1) << w) - 1;
    lim   = 10;
    n     = 1;
    for (int i = 0; i < 20; i++) begin
      if (lim <= max_v) begin
        n   = n + 1;
        lim = lim * 10;
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  localparam int unsigned BcdD = dec_digits(DATA_W);
  localparam int unsigned NB   = (BcdD > DIGITS) ? BcdD : DIGITS;
  localparam int unsigned CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned RW   = $clog2(REFRESH_DIV);
  localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned EW   = DATA_W + 4 * DIGITS;
  localparam logic [6:0]  Dash = 7'h40;

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        val_q, val_d;
  logic                     hex_q, hex_d;
  logic                     neg_q, neg_d;
  logic [DATA_W-1:0]        sh_q, sh_d;
  logic [4*NB-1:0]          bcd_q, bcd_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [DIGITS-1:0][6:0]   disp_q, disp_d;
  logic                     ovf_q, ovf_d;
  logic [RW-1:0]            ref_q, ref_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [6:0]               seg_q, seg_d;

  logic [DATA_W:0]          mag_full;
  logic                     unused_mag_msb;
  logic [4*NB-1:0]          bcd_adj;
  logic [DIGITS-1:0][6:0]   new_disp;
  logic                     new_ovf;
  logic [EW-1:0]            vext;
  int unsigned              msd;

  // Negation at DATA_W+1 bits keeps the most negative value exact.
  always_comb begin
    mag_full = {1'b0, value_in};
    if (!hex_mode && signed_mode && value_in[DATA_W-1]) begin
      mag_full = (~{value_in[DATA_W-1], value_in}) + (DATA_W + 1)'(1);
    end
  end
  assign unused_mag_msb = mag_full[DATA_W];

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < NB; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Display image computed from the finished conversion; used only in StCommit.
  always_comb begin
    new_disp = '0;
    new_ovf  = 1'b0;
    msd      = 0;
    vext     = EW'(val_q);
    if (hex_q) begin
      new_ovf = |(vext >> (4 * DIGITS));
      for (int unsigned k = 0; k < DIGITS; k++) begin
        new_disp[k] = seg_of(vext[4*k +: 4]);
      end
    end else begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (bcd_q[4*k +: 4] != 4'd0) begin
          msd = k;
          if (k >= DIGITS) new_ovf = 1'b1;
          if (neg_q && (k >= DIGITS - 1)) new_ovf = 1'b1;
        end
      end
      for (int unsigned k = 0; k < DIGITS; k++) begin
        if (k <= msd) begin
          new_disp[k] = seg_of(bcd_q[4*k +: 4]);
        end else if (neg_q && (k == msd + 1)) begin
          new_disp[k] = Dash;
        end
      end
    end
    if (new_ovf) begin
      for (int unsigned k = 0; k < DIGITS; k++) new_disp[k] = Dash;
    end
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    hex_d   = hex_q;
    neg_d   = neg_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          val_d   = value_in;
          hex_d   = hex_mode;
          neg_d   = !hex_mode && signed_mode && value_in[DATA_W-1];
          sh_d    = mag_full[DATA_W-1:0];
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = hex_mode ? StCommit : StConv;
        end
      end
      StConv: begin
        {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
        cnt_d         = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) state_d = StCommit;
      end
      StCommit: begin
        disp_d  = new_disp;
        ovf_d   = new_ovf;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan timing is free-running; seg tracks the next selected digit of the next image.
  always_comb begin
    ref_d = ref_q + RW'(1);
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    seg_d = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_d == IW'(k)) seg_d = disp_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      val_q   <= '0;
      hex_q   <= 1'b0;
      neg_q   <= 1'b0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      hex_q   <= hex_d;
      neg_q   <= neg_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    digit_sel = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) digit_sel[k] = 1'b1;
    end
  end

  assign busy     = (state_q != StIdle);
  assign overflow = ovf_q;
  assign seg_out  = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp_out   = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: five parameterisations share one stimulus stream.
module tb_seg_display_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value_in;
  logic       load;
  logic       hex_mode;
  logic       signed_mode;

  int total = 0;
  int bad   = 0;

  // 0: DIGITS=3, 1: DIGITS=1, 2: DIGITS=4, 3: DIGITS=2, 4: DIGITS=3 active-low
  logic       busy_w [5];
  logic       ovf_w  [5];
  logic [6:0] seg_w  [5];
  logic       dp_w   [5];
  logic [7:0] sel_w  [5];

  logic [2:0] sel0;
  logic [0:0] sel1;
  logic [3:0] sel2;
  logic [1:0] sel3;
  logic [2:0] sel4;

  assign sel_w[0] = 8'(sel0);
  assign sel_w[1] = 8'(sel1);
  assign sel_w[2] = 8'(sel2);
  assign sel_w[3] = 8'(sel3);
  assign sel_w[4] = 8'(sel4);

  always #5 clk = ~clk;

  seg_display_mux #(.DATA_W(8), .DIGITS(3), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_main (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .hex_mode(hex_mode),
    .signed_mode(signed_mode), .busy(busy_w[0]), .overflow(ovf_w[0]), .seg_out(seg_w[0]),
    .dp_out(dp_w[0]), .digit_sel(sel0)
  );
  seg_display_mux #(.DATA_W(8), .DIGITS(1), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_one (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .hex_mode(hex_mode),
    .signed_mode(signed_mode), .busy(busy_w[1]), .overflow(ovf_w[1]), .seg_out(seg_w[1]),
    .dp_out(dp_w[1]), .digit_sel(sel1)
  );
  seg_display_mux #(.DATA_W(8), .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_four (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .hex_mode(hex_mode),
    .signed_mode(signed_mode), .busy(busy_w[2]), .overflow(ovf_w[2]), .seg_out(seg_w[2]),
    .dp_out(dp_w[2]), .digit_sel(sel2)
  );
  seg_display_mux #(.DATA_W(8), .DIGITS(2), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_two (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .hex_mode(hex_mode),
    .signed_mode(signed_mode), .busy(busy_w[3]), .overflow(ovf_w[3]), .seg_out(seg_w[3]),
    .dp_out(dp_w[3]), .digit_sel(sel3)
  );
  seg_display_mux #(.DATA_W(8), .DIGITS(3), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) u_low (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .hex_mode(hex_mode),
    .signed_mode(signed_mode), .busy(busy_w[4]), .overflow(ovf_w[4]), .seg_out(seg_w[4]),
    .dp_out(dp_w[4]), .digit_sel(sel4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_digit(input int d, input int k, output logic [6:0] s, output logic ok);
    logic [7:0] want;
    want = 8'd1 << k;
    ok   = 1'b0;
    s    = '0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (sel_w[d] == want) begin
        s  = seg_w[d];
        ok = 1'b1;
      end
    end
  endtask

  // exp holds digit k in bits [8k+7:8k].
  task automatic check_digits(input int d, input int n, input string tag,
                              input logic [31:0] exp);
    logic [6:0] s;
    logic       ok;
    for (int k = 0; k < n; k++) begin
      read_digit(d, k, s, ok);
      check($sformatf("%s.d%0d.sel_seen", tag, k), 32'(ok), 32'd1);
      if (ok) check($sformatf("%s.d%0d", tag, k), 32'(s), 32'(exp[8*k +: 8]));
    end
  endtask

  task automatic do_load(input logic [7:0] v, input logic hx, input logic sg, output int n);
    value_in    = v;
    hex_mode    = hx;
    signed_mode = sg;
    load        = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n    = 0;
    while (busy_w[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    value_in    = '0;
    load        = 1'b0;
    hex_mode    = 1'b0;
    signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.seg", 32'(seg_w[0]), 32'h00);
    check("rst.sel", 32'(sel_w[0]), 32'h1);
    check("rst.busy", 32'(busy_w[0]), 32'd0);
    check("rst.ovf", 32'(ovf_w[0]), 32'd0);
    check("rst.dp", 32'(dp_w[0]), 32'd0);
    check("rst.low_seg", 32'(seg_w[4]), 32'h7F);
    check("rst.low_dp", 32'(dp_w[4]), 32'd1);
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check($sformatf("scan.%0d", i), 32'(sel_w[0]), 32'(1 << ((i / 4) % 3)));
    end

    do_load(8'd42, 1'b0, 1'b0, n);
    check("dec42.busy_cycles", 32'(n), 32'd9);
    check("dec42.ovf", 32'(ovf_w[0]), 32'd0);
    check_digits(0, 3, "dec42", 32'h00665B);
    check_digits(4, 3, "dec42_low", 32'h7F1924);

    do_load(8'd255, 1'b0, 1'b0, n);
    check_digits(0, 3, "dec255", 32'h5B6D6D);
    do_load(8'd0, 1'b0, 1'b0, n);
    check_digits(0, 3, "dec0", 32'h00003F);

    do_load(8'hA5, 1'b1, 1'b0, n);
    check("hexA5.busy_cycles", 32'(n), 32'd1);
    check("hexA5.ovf", 32'(ovf_w[0]), 32'd0);
    check_digits(0, 3, "hexA5", 32'h3F776D);
    check("hexA5_d1.ovf", 32'(ovf_w[1]), 32'd1);
    check_digits(1, 1, "hexA5_d1", 32'h40);

    do_load(8'hFB, 1'b0, 1'b1, n);
    check("sgnFB.ovf", 32'(ovf_w[0]), 32'd0);
    check_digits(0, 3, "sgnFB", 32'h00406D);

    do_load(8'h80, 1'b0, 1'b1, n);
    check("sgn80.ovf", 32'(ovf_w[0]), 32'd1);
    check_digits(0, 3, "sgn80", 32'h404040);
    check("sgn80_d4.ovf", 32'(ovf_w[2]), 32'd0);
    check_digits(2, 4, "sgn80_d4", 32'h40065B7F);

    do_load(8'd100, 1'b0, 1'b0, n);
    check("dec100_d2.ovf", 32'(ovf_w[3]), 32'd1);
    check_digits(3, 2, "dec100_d2", 32'h4040);
    check("dec100.ovf", 32'(ovf_w[0]), 32'd0);
    check_digits(0, 3, "dec100", 32'h063F3F);

    // A second load during conversion must be dropped.
    value_in = 8'd42;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    value_in = 8'd7;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n    = 0;
    while (busy_w[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("intf.busy_done", 32'(busy_w[0]), 32'd0);
    check_digits(0, 3, "intf", 32'h00665B);

    // Reset in the fourth conversion cycle.
    value_in = 8'd42;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.busy", 32'(busy_w[0]), 32'd0);
    check("midrst.ovf", 32'(ovf_w[0]), 32'd0);
    check_digits(0, 3, "midrst", 32'h000000);
    do_load(8'd9, 1'b0, 1'b0, n);
    check("dec9.busy_cycles", 32'(n), 32'd9);
    check_digits(0, 3, "dec9", 32'h00006F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
